// File: rtl/hline_setup.sv
// Span setup for the horizontal-line z-buffer engine: orders endpoints, computes addresses and
// depth-interpolation terms with a restoring divider, then launches the engine and waits for done.
module hline_setup #(
  parameter int unsigned LINE_PITCH = 640,
  parameter int unsigned DIV_BITS   = 32
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic [15:0] y,
  input  logic [31:0] z1,
  input  logic [31:0] z2,
  input  logic [31:0] rgbx_in,
  input  logic [31:0] fb_base,
  input  logic [31:0] zb_base,
  output logic [31:0] fb_addr,
  output logic [31:0] zbuff_addr,
  output logic [31:0] dx,
  output logic [31:0] slope,
  output logic [31:0] rem,
  output logic [31:0] err,
  output logic [31:0] z1_out,
  output logic [31:0] rgbx,
  output logic        hline_start,
  input  logic        hline_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StDiv, StLaunch, StWaitLow, StWaitHigh
  } state_e;

  state_e              r_state;
  logic [15:0]         r_x1, r_x2, r_y;
  logic [30:0]         r_z1, r_z2;
  logic [31:0]         r_fb_base, r_zb_base;
  logic                r_sign;
  logic [DIV_BITS-1:0] r_quo;
  logic [31:0]         r_part;
  logic [15:0]         r_divisor;
  logic [5:0]          r_cnt;

  logic                w_swap;
  logic [15:0]         w_x_start;
  logic [15:0]         w_dx;
  logic [30:0]         w_z_start;
  logic [30:0]         w_z_end;
  logic [32:0]         w_dz;
  logic [31:0]         w_abs_dz;
  logic [31:0]         w_pix_off;
  logic [32:0]         w_shift;
  logic                w_qbit;
  logic [31:0]         w_part_next;
  logic [DIV_BITS-1:0] w_quo_next;

  assign cmd_ready = (r_state == StIdle);
  assign busy      = ~cmd_ready;
  assign err       = '0;

  always_comb begin
    w_swap    = r_x1 > r_x2;
    w_x_start = w_swap ? r_x2 : r_x1;
    w_dx      = w_swap ? (r_x1 - r_x2) : (r_x2 - r_x1);
    w_z_start = w_swap ? r_z2 : r_z1;
    w_z_end   = w_swap ? r_z1 : r_z2;
    // 33-bit signed difference of two 31-bit depths; bit 32 is the sign
    w_dz      = {2'b00, w_z_end} - {2'b00, w_z_start};
    w_abs_dz  = w_dz[32] ? 32'(~w_dz + 33'd1) : w_dz[31:0];
    w_pix_off = (32'(r_y) * 32'(LINE_PITCH) + 32'(w_x_start)) << 2;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    w_shift     = {r_part, r_quo[DIV_BITS-1]};
    w_qbit      = (w_shift >= 33'(r_divisor));
    w_part_next = w_qbit ? 32'(w_shift - 33'(r_divisor)) : w_shift[31:0];
    w_quo_next  = {r_quo[DIV_BITS-2:0], w_qbit};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= StIdle;
      r_x1        <= '0;
      r_x2        <= '0;
      r_y         <= '0;
      r_z1        <= '0;
      r_z2        <= '0;
      r_fb_base   <= '0;
      r_zb_base   <= '0;
      r_sign      <= 1'b0;
      r_quo       <= '0;
      r_part      <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      fb_addr     <= '0;
      zbuff_addr  <= '0;
      dx          <= '0;
      slope       <= '0;
      rem         <= '0;
      z1_out      <= '0;
      rgbx        <= '0;
      hline_start <= 1'b0;
    end else begin
      hline_start <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_x1      <= x1;
            r_x2      <= x2;
            r_y       <= y;
            r_z1      <= z1[30:0];
            r_z2      <= z2[30:0];
            r_fb_base <= fb_base;
            r_zb_base <= zb_base;
            rgbx      <= rgbx_in;
            r_state   <= StSetup;
          end
        end
        StSetup: begin
          dx         <= 32'(w_dx);
          z1_out     <= {1'b0, w_z_start};
          fb_addr    <= r_fb_base + w_pix_off;
          zbuff_addr <= r_zb_base + w_pix_off;
          r_sign     <= w_dz[32];
          if (w_dx == 16'd0) begin
            slope   <= '0;
            rem     <= '0;
            r_state <= StIdle;
          end else begin
            r_quo     <= DIV_BITS'(w_abs_dz);
            r_part    <= '0;
            r_divisor <= w_dx;
            r_cnt     <= '0;
            r_state   <= StDiv;
          end
        end
        StDiv: begin
          r_quo  <= w_quo_next;
          r_part <= w_part_next;
          r_cnt  <= r_cnt + 6'd1;
          if (r_cnt == 6'(DIV_BITS - 1)) begin
            slope       <= r_sign ? 32'(-w_quo_next) : 32'(w_quo_next);
            rem         <= w_part_next;
            hline_start <= 1'b1;
            r_state     <= StLaunch;
          end
        end
        StLaunch:   r_state <= StWaitLow;
        // Done may still be high from the previous span; wait for it to drop first
        StWaitLow:  if (!hline_done) r_state <= StWaitHigh;
        StWaitHigh: if (hline_done) r_state <= StIdle;
        default:    r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hline_setup.sv
// Scoreboard bench for hline_setup: stimulus pushes model results, a monitor pops and compares
// on each launch pulse or zero-length completion; a small engine model drives hline_done.
module tb_hline_setup;
  localparam int unsigned Pitch = 640;

  logic        clk = 1'b0;
  logic        nreset;
  logic        cmd_valid, cmd_ready;
  logic [15:0] x1, x2, y;
  logic [31:0] z1, z2, rgbx_in, fb_base, zb_base;
  logic [31:0] fb_addr, zbuff_addr, dx, slope, rem, err, z1_out, rgbx;
  logic        hline_start, hline_done, busy;

  hline_setup #(.LINE_PITCH(Pitch), .DIV_BITS(32)) dut (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x1(x1), .x2(x2), .y(y), .z1(z1), .z2(z2), .rgbx_in(rgbx_in),
    .fb_base(fb_base), .zb_base(zb_base), .fb_addr(fb_addr), .zbuff_addr(zbuff_addr),
    .dx(dx), .slope(slope), .rem(rem), .err(err), .z1_out(z1_out), .rgbx(rgbx),
    .hline_start(hline_start), .hline_done(hline_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dx, slope, rem, z1, fb, zb, rgbx;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   eng_lat = 3;
  int   hold_high = 0;
  bit   abort = 1'b0;
  bit   prev_busy = 1'b0;
  bit   saw_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: order by column, divide depth delta by column delta with plain integer math
  function automatic exp_t model(input logic [15:0] ax1, ax2, ay,
                                 input logic [31:0] az1, az2, argb, afb, azb, input int t);
    exp_t   e;
    longint zs, ze, dz, adz, off;
    int     xs, d;
    if (ax1 <= ax2) begin
      xs = int'(ax1); d = int'(ax2) - int'(ax1);
      zs = longint'(az1 & 32'h7fff_ffff); ze = longint'(az2 & 32'h7fff_ffff);
    end else begin
      xs = int'(ax2); d = int'(ax1) - int'(ax2);
      zs = longint'(az2 & 32'h7fff_ffff); ze = longint'(az1 & 32'h7fff_ffff);
    end
    dz  = ze - zs;
    adz = (dz < 0) ? -dz : dz;
    e.dx = 32'(d);
    if (d == 0) begin
      e.slope = '0;
      e.rem   = '0;
    end else begin
      e.slope = 32'((dz < 0) ? -(adz / d) : (adz / d));
      e.rem   = 32'(adz % d);
    end
    off    = (longint'(ay) * Pitch + xs) * 4;
    e.z1   = 32'(zs);
    e.fb   = afb + 32'(off);
    e.zb   = azb + 32'(off);
    e.rgbx = argb;
    e.t    = t;
    return e;
  endfunction

  task automatic cmp_fields(input exp_t e);
    chk("dx", dx, e.dx);
    chk("slope", slope, e.slope);
    chk("rem", rem, e.rem);
    chk("err", err, 32'd0);
    chk("z1_out", z1_out, e.z1);
    chk("fb_addr", fb_addr, e.fb);
    chk("zbuff_addr", zbuff_addr, e.zb);
    chk("rgbx", rgbx, e.rgbx);
  endtask

  // Monitor: a launch pulse or a zero-length completion presents a result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (hline_start === 1'b1) begin
        saw_start = 1'b1;
        if (sb.size() == 0) chk("start_unexpected", {31'b0, hline_start}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("start_cycle", 32'(cyc), 32'(e.t + 34));
          cmp_fields(e);
        end
      end
      if (prev_busy && !busy) begin
        if (abort) abort = 1'b0;
        else if (!saw_start) begin
          if (sb.size() == 0) chk("idle_no_span", 32'(sb.size()), 32'd1);
          else begin
            e = sb.pop_front();
            chk("zero_dx_idle_cycle", 32'(cyc), 32'(e.t + 2));
            cmp_fields(e);
          end
        end
        saw_start = 1'b0;
      end
      prev_busy = busy;
    end
  end

  // Line-engine model: done is a level, dropped the cycle after launch unless held
  initial begin
    hline_done = 1'b1;
    forever begin
      @(negedge clk);
      if (hline_start === 1'b1) begin
        @(negedge clk);
        for (int i = 0; i < hold_high; i++) begin
          chk("wait_low_hold_busy", {31'b0, busy}, 32'd1);
          @(negedge clk);
        end
        hline_done = 1'b0;
        repeat (eng_lat) @(negedge clk);
        chk("busy_before_done", {31'b0, busy}, 32'd1);
        hline_done = 1'b1;
        @(negedge clk);
        chk("idle_after_done", {31'b0, cmd_ready}, 32'd1);
      end
    end
  end

  task automatic send(input logic [15:0] ax1, ax2, ay, input logic [31:0] az1, az2, argb,
                      input logic [31:0] afb, azb, input int lat, hold, input bit push,
                      output int t);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'b0, cmd_ready}, 32'd1);
      t = -1;
      return;
    end
    eng_lat = lat;
    hold_high = hold;
    x1 = ax1; x2 = ax2; y = ay; z1 = az1; z2 = az2;
    rgbx_in = argb; fb_base = afb; zb_base = azb;
    cmd_valid = 1'b1;
    t = cyc;
    if (push) sb.push_back(model(ax1, ax2, ay, az1, az2, argb, afb, azb, t));
    @(negedge clk);
    cmd_valid = 1'b0;
    x1 = 16'($urandom); x2 = 16'($urandom); z1 = $urandom; z2 = $urandom;
    rgbx_in = $urandom; fb_base = $urandom;
  endtask

  initial begin
    int t;
    int w;
    logic [15:0] rx1, rx2;
    nreset = 1'b0; cmd_valid = 1'b0;
    x1 = '0; x2 = '0; y = '0; z1 = '0; z2 = '0; rgbx_in = '0; fb_base = '0; zb_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hline_start", {31'b0, hline_start}, 32'd0);
    chk("rst_fb_addr", fb_addr, 32'd0);
    chk("rst_zbuff_addr", zbuff_addr, 32'd0);
    chk("rst_slope", slope, 32'd0);
    chk("rst_z1_out", z1_out, 32'd0);
    chk("rst_rgbx", rgbx, 32'd0);
    nreset = 1'b1;

    send(16'd10, 16'd20, 16'd2, 32'd100, 32'd135, 32'hAABB_CCDD, 32'h1000_0000,
         32'h2000_0000, 3, 0, 1'b1, t);
    send(16'd20, 16'd10, 16'd2, 32'd135, 32'd100, 32'hAABB_CCDD, 32'h1000_0000,
         32'h2000_0000, 3, 0, 1'b1, t);
    send(16'd10, 16'd20, 16'd2, 32'd200, 32'd165, 32'h0102_0304, 32'h1000_0000,
         32'h2000_0000, 2, 0, 1'b1, t);
    send(16'd7, 16'd7, 16'd5, 32'd50, 32'hFFFF_FFFF, 32'h5555_AAAA, 32'h0000_4000,
         32'h0008_0000, 2, 0, 1'b1, t);
    // Engine raises done 265 cycles after dropping it: accept T, drop T+35, raise T+300
    send(16'd3, 16'd300, 16'd479, 32'h8000_0010, 32'h7FFF_0000, 32'h1234_5678, 32'h0100_0000,
         32'h0200_0000, 265, 0, 1'b1, t);
    // Done held high long after launch: setup must stay parked
    send(16'd500, 16'd1, 16'd100, 32'h0000_1000, 32'h0FFF_0000, 32'hCAFE_F00D, 32'h0,
         32'h4000_0000, 4, 60, 1'b1, t);

    // Reset in the middle of the divide
    send(16'd0, 16'd999, 16'd33, 32'd1, 32'd123456, 32'hDEAD_BEEF, 32'h10, 32'h20,
         3, 0, 1'b0, t);
    repeat (14) @(negedge clk);
    abort = 1'b1;
    nreset = 1'b0;
    #1;
    chk("midreset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_hline_start", {31'b0, hline_start}, 32'd0);
    chk("midreset_slope", slope, 32'd0);
    chk("midreset_fb_addr", fb_addr, 32'd0);
    chk("midreset_dx", dx, 32'd0);
    chk("midreset_rgbx", rgbx, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    send(16'd64, 16'd32, 16'd7, 32'd9000, 32'd1000, 32'h0BAD_CAFE, 32'h2000_0000,
         32'h3000_0000, 1, 0, 1'b1, t);

    for (int i = 0; i < 40; i++) begin
      rx1 = 16'($urandom_range(0, 1023));
      rx2 = ($urandom_range(0, 5) == 0) ? rx1 : 16'($urandom_range(0, 1023));
      send(rx1, rx2, 16'($urandom_range(0, 479)), $urandom, $urandom, $urandom,
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b1, t);
    end

    w = 0;
    while ((sb.size() != 0 || !cmd_ready) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
